mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter ILLEGAL_HALT, default 0: when 1, an illegal instruction parks the FSM in HALT; when 0, it is skipped.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 instr  in  32  current instruction word from fetch stage (insout).
REQ-005 zero  in  1  ALU equality flag, used for beq.
REQ-006 ir_wr  out  1  instruction-register load strobe.
REQ-007 pc_wr  out  1  PC update strobe to fetch stage.
REQ-008 npc_sel, j, jal, jr  out  1 each  next-PC selects to fetch stage.
REQ-009 reg_wr  out  1  register-file write enable.
REQ-010 mem_wr  out  1  data-memory write enable.
REQ-011 alu_op  out  3  0=add, 1=sub, 2=or, 3=lui-shift.
REQ-012 alu_src  out  1  1 = extended immediate, 0 = rt.
REQ-013 ext_op  out  2  0=zero-ext, 1=sign-ext, 2=upper16.
REQ-014 reg_dst  out  2  0=rt, 1=rd, 2=r31.
REQ-015 wd_sel  out  2  0=ALU, 1=memory, 2=pc+4.
REQ-016 illegal  out  1  one-cycle pulse on an undecodable instruction.
REQ-017 state  out  4  current FSM state encoding (debug).
REQ-018 instret  out  32  retired-instruction count.

Function
REQ-019 Supported instructions: addu, subu, jr (op 000000, funct 100001/100011/001000); ori 001101; lw 100011; sw 101011; beq 000100; lui 001111; j 000010; jal 000011. Every other encoding is illegal.
REQ-020 States: FETCH, DCD, EXE, MA, WB, BR, JMP, HALT.
REQ-021 FETCH: ir_wr=1; next state DCD unconditionally.
REQ-022 DCD transitions: R-ALU/ori/lui/lw/sw -> EXE; beq -> BR; j/jal/jr -> JMP; illegal -> FETCH with pc_wr=1 and illegal=1, or -> HALT with illegal=1 when ILLEGAL_HALT=1.
REQ-023 EXE transitions: lw/sw -> MA; all others -> WB. Drive alu_op, alu_src, and ext_op for the decoded instruction.
REQ-024 MA: lw -> WB; sw: mem_wr=1 and pc_wr=1, then -> FETCH.
REQ-025 WB: reg_wr=1 and pc_wr=1, with reg_dst/wd_sel per instruction; then -> FETCH.
REQ-026 BR: alu_op=sub, npc_sel=1, pc_wr=1; then -> FETCH. The branch outcome comes from zero in that same cycle.
REQ-027 JMP: pc_wr=1 with j, jal, or jr asserted. jal also drives reg_wr=1, reg_dst=2, wd_sel=2. Then -> FETCH.
REQ-028 Strobes (ir_wr, pc_wr, reg_wr, mem_wr, illegal) are Moore/decoded outputs, 0 outside the states listed above.
REQ-029 Exactly one pc_wr pulse per instruction, including an illegal skip.
REQ-030 Latencies: R/ori/lui = 4 cycles; lw = 5; sw = 4; beq/j/jal/jr = 3.
REQ-031 HALT is absorbing; only reset exits it. All strobes are 0 in HALT.
REQ-032 instr changes in states other than FETCH are ignored; decode uses a latched copy captured with ir_wr.

Reset
REQ-033 reset=1 at a clock edge forces state=FETCH, the latched instr copy to 0, and instret to 0, regardless of current state, including mid-instruction and HALT.
REQ-034 While reset is held, all strobe outputs are 0.
REQ-035 The first FETCH occurs in the cycle after reset deasserts.

Configuration
REQ-036 With CTRL_PERF_CNT_EN defined, instret increments by 1 on every pc_wr cycle that is not an illegal skip, and wraps 0xFFFFFFFF -> 0.
REQ-037 Without CTRL_PERF_CNT_EN, instret is tied to 0 and no counter register exists.

Structure
REQ-038 Package mc_pkg holds: state encodings, opcode/funct constants, and alu_op, ext_op, reg_dst, and wd_sel codes.
REQ-039 Sub-module mc_decode is purely combinational: latched instr -> instruction class and datapath selects.
REQ-040 mc_ctrl owns the FSM, the instruction latch, and the counter.

Verification
REQ-041 Reset, then instr=0x00221821 (addu) -> states FETCH, DCD, EXE, WB; reg_wr=1, reg_dst=1, pc_wr=1 in cycle 4 only; instret=1.
REQ-042 instr=0x8C220004 (lw) -> 5 cycles; in WB: wd_sel=1, reg_dst=0, ext_op=1; mem_wr is never 1.
REQ-043 instr=0x10220003 (beq) with zero=1 in BR -> npc_sel=1 and pc_wr=1 in cycle 3; state returns to FETCH.
REQ-044 instr=0x0C000C00 (jal) -> in JMP: jal=1, reg_wr=1, reg_dst=2, wd_sel=2, pc_wr=1.
REQ-045 instr=0xFC000000 with ILLEGAL_HALT=0 -> illegal=1 and pc_wr=1 in DCD, instret unchanged. With ILLEGAL_HALT=1 -> state=HALT held for 10 cycles; reset returns to FETCH.
REQ-046 reset asserted during MA of sw -> mem_wr never pulses, and state=FETCH the next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle controller -- FSM states,
// opcode/funct constants, instruction classes and datapath select codes.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH = 4'd0,
      DCD   = 4'd1,
      EXE   = 4'd2,
      MA    = 4'd3,
      WB    = 4'd4,
      BR    = 4'd5,
      JMP   = 4'd6,
      HALT  = 4'd7
   } state_t;

   typedef enum logic [3:0] {
      CLS_ILLEGAL = 4'd0,
      CLS_RALU    = 4'd1,
      CLS_ORI     = 4'd2,
      CLS_LUI     = 4'd3,
      CLS_LW      = 4'd4,
      CLS_SW      = 4'd5,
      CLS_BEQ     = 4'd6,
      CLS_J       = 4'd7,
      CLS_JAL     = 4'd8,
      CLS_JR      = 4'd9
   } instr_class_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_LUI  = 3'd3;

   localparam logic [1:0] EXT_ZERO  = 2'd0;
   localparam logic [1:0] EXT_SIGN  = 2'd1;
   localparam logic [1:0] EXT_UPPER = 2'd2;

   localparam logic [1:0] RD_RT    = 2'd0;
   localparam logic [1:0] RD_RD    = 2'd1;
   localparam logic [1:0] RD_R31   = 2'd2;

   localparam logic [1:0] WD_ALU   = 2'd0;
   localparam logic [1:0] WD_MEM   = 2'd1;
   localparam logic [1:0] WD_PC4   = 2'd2;

endpackage

// File: rtl/mc_if.sv
// mc_if: bus between the multicycle controller and the fetch/datapath side.
// The slave modport is the controller; the master modport is whoever supplies
// the instruction word and ALU flag and consumes the control strobes.
interface mc_if;
   logic [31:0] instr;
   logic        zero;
   logic        ir_wr;
   logic        pc_wr;
   logic        npc_sel;
   logic        j;
   logic        jal;
   logic        jr;
   logic        reg_wr;
   logic        mem_wr;
   logic [2:0]  alu_op;
   logic        alu_src;
   logic [1:0]  ext_op;
   logic [1:0]  reg_dst;
   logic [1:0]  wd_sel;
   logic        illegal;
   logic [3:0]  state;
   logic [31:0] instret;

   modport slave (
      input  instr, zero,
      output ir_wr, pc_wr, npc_sel, j, jal, jr, reg_wr, mem_wr,
             alu_op, alu_src, ext_op, reg_dst, wd_sel, illegal, state, instret
   );

   modport master (
      output instr, zero,
      input  ir_wr, pc_wr, npc_sel, j, jal, jr, reg_wr, mem_wr,
             alu_op, alu_src, ext_op, reg_dst, wd_sel, illegal, state, instret
   );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: purely combinational decoder from the latched instruction word
// to an instruction class plus the datapath selects that class needs.
module mc_decode
   import mc_pkg::*;
(
   input  logic [31:0]  i_instr,
   output instr_class_t o_class,
   output logic [2:0]   o_aluOp,
   output logic         o_aluSrc,
   output logic [1:0]   o_extOp,
   output logic [1:0]   o_regDst,
   output logic [1:0]   o_wdSel
);

   logic [5:0] w_op;
   logic [5:0] w_funct;
   logic       w_unusedFields;

   assign w_op           = i_instr[31:26];
   assign w_funct        = i_instr[5:0];
   // Register and immediate fields are consumed by the datapath, not here.
   assign w_unusedFields = ^i_instr[25:6];

   // Classify opcode/funct; anything not matched stays illegal with neutral selects
   always_comb begin
      o_class  = CLS_ILLEGAL;
      o_aluOp  = ALU_ADD;
      o_aluSrc = 1'b0;
      o_extOp  = EXT_ZERO;
      o_regDst = RD_RT;
      o_wdSel  = WD_ALU;
      case (w_op)
         OP_RTYPE: begin
            case (w_funct)
               FN_ADDU: begin
                  o_class  = CLS_RALU;
                  o_regDst = RD_RD;
               end
               FN_SUBU: begin
                  o_class  = CLS_RALU;
                  o_aluOp  = ALU_SUB;
                  o_regDst = RD_RD;
               end
               FN_JR:   o_class = CLS_JR;
               default: ;
            endcase
         end
         OP_ORI: begin
            o_class  = CLS_ORI;
            o_aluOp  = ALU_OR;
            o_aluSrc = 1'b1;
            o_extOp  = EXT_ZERO;
         end
         OP_LUI: begin
            o_class  = CLS_LUI;
            o_aluOp  = ALU_LUI;
            o_aluSrc = 1'b1;
            o_extOp  = EXT_UPPER;
         end
         OP_LW: begin
            o_class  = CLS_LW;
            o_aluSrc = 1'b1;
            o_extOp  = EXT_SIGN;
            o_wdSel  = WD_MEM;
         end
         OP_SW: begin
            o_class  = CLS_SW;
            o_aluSrc = 1'b1;
            o_extOp  = EXT_SIGN;
         end
         OP_BEQ: begin
            o_class  = CLS_BEQ;
            o_aluOp  = ALU_SUB;
            o_extOp  = EXT_SIGN;
         end
         OP_J:    o_class = CLS_J;
         OP_JAL: begin
            o_class  = CLS_JAL;
            o_regDst = RD_R31;
            o_wdSel  = WD_PC4;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset controller. Owns the FSM, the instruction
// latch and the retired-instruction counter. Define CTRL_PERF_CNT_EN to build
// the instret counter; otherwise instret reads as zero.
// ILLEGAL_HALT=1 parks the FSM in HALT on an undecodable instruction.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter bit ILLEGAL_HALT = 1'b0
)
(
   input  logic clk,
   input  logic reset,
   mc_if.slave  bus
);

   state_t       r_state;
   logic [31:0]  r_instr;

   instr_class_t w_class;
   logic [2:0]   w_aluOp;
   logic         w_aluSrc;
   logic [1:0]   w_extOp;
   logic [1:0]   w_regDst;
   logic [1:0]   w_wdSel;

   logic w_irWr;
   logic w_pcWr;
   logic w_npcSel;
   logic w_j;
   logic w_jal;
   logic w_jr;
   logic w_regWr;
   logic w_memWr;
   logic w_illegal;
   logic w_unusedZero;

   // Branch resolution happens in the fetch stage, which sees zero directly.
   assign w_unusedZero = bus.zero;

   mc_decode u_decode (
      .i_instr  (r_instr),
      .o_class  (w_class),
      .o_aluOp  (w_aluOp),
      .o_aluSrc (w_aluSrc),
      .o_extOp  (w_extOp),
      .o_regDst (w_regDst),
      .o_wdSel  (w_wdSel)
   );

   // State sequencing; the instruction word is captured only on leaving FETCH
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FETCH;
         r_instr <= '0;
      end else begin
         case (r_state)
            FETCH: begin
               r_instr <= bus.instr;
               r_state <= DCD;
            end
            DCD: begin
               case (w_class)
                  CLS_RALU, CLS_ORI, CLS_LUI, CLS_LW, CLS_SW: r_state <= EXE;
                  CLS_BEQ:                                    r_state <= BR;
                  CLS_J, CLS_JAL, CLS_JR:                     r_state <= JMP;
                  default: begin
                     if (ILLEGAL_HALT) r_state <= HALT;
                     else              r_state <= FETCH;
                  end
               endcase
            end
            EXE: begin
               if (w_class == CLS_LW || w_class == CLS_SW) r_state <= MA;
               else                                         r_state <= WB;
            end
            MA: begin
               if (w_class == CLS_LW) r_state <= WB;
               else                   r_state <= FETCH;
            end
            WB, BR, JMP: r_state <= FETCH;
            HALT:        r_state <= HALT;
            default:     r_state <= FETCH;
         endcase
      end
   end

   // Moore strobes decoded from state and class; all held low while reset is asserted
   always_comb begin
      w_irWr    = 1'b0;
      w_pcWr    = 1'b0;
      w_npcSel  = 1'b0;
      w_j       = 1'b0;
      w_jal     = 1'b0;
      w_jr      = 1'b0;
      w_regWr   = 1'b0;
      w_memWr   = 1'b0;
      w_illegal = 1'b0;
      if (!reset) begin
         case (r_state)
            FETCH: w_irWr = 1'b1;
            DCD: begin
               if (w_class == CLS_ILLEGAL) begin
                  w_illegal = 1'b1;
                  w_pcWr    = !ILLEGAL_HALT;
               end
            end
            MA: begin
               if (w_class == CLS_SW) begin
                  w_memWr = 1'b1;
                  w_pcWr  = 1'b1;
               end
            end
            WB: begin
               w_regWr = 1'b1;
               w_pcWr  = 1'b1;
            end
            BR: begin
               w_npcSel = 1'b1;
               w_pcWr   = 1'b1;
            end
            JMP: begin
               w_pcWr  = 1'b1;
               w_j     = (w_class == CLS_J);
               w_jal   = (w_class == CLS_JAL);
               w_jr    = (w_class == CLS_JR);
               w_regWr = (w_class == CLS_JAL);
            end
            default: ;
         endcase
      end
   end

   assign bus.ir_wr   = w_irWr;
   assign bus.pc_wr   = w_pcWr;
   assign bus.npc_sel = w_npcSel;
   assign bus.j       = w_j;
   assign bus.jal     = w_jal;
   assign bus.jr      = w_jr;
   assign bus.reg_wr  = w_regWr;
   assign bus.mem_wr  = w_memWr;
   assign bus.illegal = w_illegal;
   assign bus.alu_op  = (r_state == BR) ? ALU_SUB : w_aluOp;
   assign bus.alu_src = w_aluSrc;
   assign bus.ext_op  = w_extOp;
   assign bus.reg_dst = w_regDst;
   assign bus.wd_sel  = w_wdSel;
   assign bus.state   = r_state;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] r_instret;

   // Count every PC update except the one that skips an illegal word; wraps naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         r_instret <= '0;
      end else if (w_pcWr && !w_illegal) begin
         r_instret <= r_instret + 32'd1;
      end
   end

   assign bus.instret = r_instret;
`else
   assign bus.instret = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed scoreboard bench for mc_ctrl. Two instances are built,
// one skipping illegal words and one halting on them.
module tb_mc_ctrl;
   import mc_pkg::*;

   localparam logic [8:0] S_IR  = 9'h100;
   localparam logic [8:0] S_PC  = 9'h080;
   localparam logic [8:0] S_NPC = 9'h040;
   localparam logic [8:0] S_J   = 9'h020;
   localparam logic [8:0] S_JAL = 9'h010;
   localparam logic [8:0] S_JR  = 9'h008;
   localparam logic [8:0] S_REG = 9'h004;
   localparam logic [8:0] S_MEM = 9'h002;
   localparam logic [8:0] S_ILL = 9'h001;

   typedef struct packed {
      logic [3:0]  state;
      logic [8:0]  stb;
      logic [4:0]  mask;
      logic [2:0]  aluOp;
      logic        aluSrc;
      logic [1:0]  extOp;
      logic [1:0]  regDst;
      logic [1:0]  wdSel;
      logic [31:0] instret;
   } exp_t;

   logic        clk;
   logic        reset;
   exp_t        expQ[$];
   string       tagQ[$];
   int          checkCount;
   int          passCount;
   int          failCount;
   logic [31:0] modelInstret;

   mc_if bus0 ();
   mc_if bus1 ();

   mc_ctrl #(.ILLEGAL_HALT(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
   mc_ctrl #(.ILLEGAL_HALT(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input int sel, input logic [31:0] word, input logic zeroVal);
      if (sel == 0) begin
         bus0.instr = word;
         bus0.zero  = zeroVal;
      end else begin
         bus1.instr = word;
         bus1.zero  = zeroVal;
      end
   endtask

   task automatic pushExp(input string tag, input state_t st, input logic [8:0] stb,
                          input logic [4:0] mask, input logic [2:0] aluOp, input logic aluSrc,
                          input logic [1:0] extOp, input logic [1:0] regDst, input logic [1:0] wdSel);
      exp_t e;
      e.state  = st;
      e.stb    = stb;
      e.mask   = mask;
      e.aluOp  = aluOp;
      e.aluSrc = aluSrc;
      e.extOp  = extOp;
      e.regDst = regDst;
      e.wdSel  = wdSel;
`ifdef CTRL_PERF_CNT_EN
      e.instret = modelInstret;
`else
      e.instret = 32'd0;
`endif
      if ((stb & S_PC) != 9'h000 && (stb & S_ILL) == 9'h000)
         modelInstret = modelInstret + 32'd1;
      expQ.push_back(e);
      tagQ.push_back(tag);
   endtask

   task automatic pushStb(input string tag, input state_t st, input logic [8:0] stb);
      pushExp(tag, st, stb, 5'b00000, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0);
   endtask

   task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Pop one expectation per cycle and compare at the negedge; instr is
   // scrambled between cycles to show decode works from the latched copy.
   task automatic checkOutput(input int n, input int sel);
      exp_t        e;
      string       t;
      logic [3:0]  oState;
      logic [8:0]  oStb;
      logic [2:0]  oAluOp;
      logic        oAluSrc;
      logic [1:0]  oExtOp;
      logic [1:0]  oRegDst;
      logic [1:0]  oWdSel;
      logic [31:0] oInstret;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (sel == 0) begin
            oState   = bus0.state;
            oStb     = {bus0.ir_wr, bus0.pc_wr, bus0.npc_sel, bus0.j, bus0.jal, bus0.jr,
                        bus0.reg_wr, bus0.mem_wr, bus0.illegal};
            oAluOp   = bus0.alu_op;
            oAluSrc  = bus0.alu_src;
            oExtOp   = bus0.ext_op;
            oRegDst  = bus0.reg_dst;
            oWdSel   = bus0.wd_sel;
            oInstret = bus0.instret;
         end else begin
            oState   = bus1.state;
            oStb     = {bus1.ir_wr, bus1.pc_wr, bus1.npc_sel, bus1.j, bus1.jal, bus1.jr,
                        bus1.reg_wr, bus1.mem_wr, bus1.illegal};
            oAluOp   = bus1.alu_op;
            oAluSrc  = bus1.alu_src;
            oExtOp   = bus1.ext_op;
            oRegDst  = bus1.reg_dst;
            oWdSel   = bus1.wd_sel;
            oInstret = bus1.instret;
         end
         if (expQ.size() == 0) begin
            checkCount++;
            failCount++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
         end else begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkField({t, ".state"},   {28'd0, oState}, {28'd0, e.state});
            checkField({t, ".strobes"}, {23'd0, oStb},   {23'd0, e.stb});
            checkField({t, ".instret"}, oInstret,        e.instret);
            if (e.mask[4]) checkField({t, ".alu_op"},  {29'd0, oAluOp},  {29'd0, e.aluOp});
            if (e.mask[3]) checkField({t, ".alu_src"}, {31'd0, oAluSrc}, {31'd0, e.aluSrc});
            if (e.mask[2]) checkField({t, ".ext_op"},  {30'd0, oExtOp},  {30'd0, e.extOp});
            if (e.mask[1]) checkField({t, ".reg_dst"}, {30'd0, oRegDst}, {30'd0, e.regDst});
            if (e.mask[0]) checkField({t, ".wd_sel"},  {30'd0, oWdSel},  {30'd0, e.wdSel});
         end
         @(posedge clk);
         #1;
         if (i < n - 1) begin
            if (sel == 0) bus0.instr = $urandom();
            else          bus1.instr = $urandom();
         end
      end
   endtask

   // Four-cycle register/immediate ALU instruction on the skipping instance
   task automatic runAlu(input string name, input logic [31:0] word, input logic [2:0] aluOp,
                         input logic aluSrc, input logic [1:0] extOp, input logic [4:0] exeMask,
                         input logic [1:0] regDst);
      applyStimulus(0, word, 1'b0);
      pushStb({name, ".fetch"}, FETCH, S_IR);
      pushStb({name, ".dcd"}, DCD, 9'h000);
      pushExp({name, ".exe"}, EXE, 9'h000, exeMask, aluOp, aluSrc, extOp, 2'd0, 2'd0);
      pushExp({name, ".wb"}, WB, S_PC | S_REG, 5'b00011, 3'd0, 1'b0, 2'd0, regDst, 2'd0);
      checkOutput(4, 0);
   endtask

   initial begin
      reset        = 1'b1;
      bus0.instr   = '0;
      bus0.zero    = 1'b0;
      bus1.instr   = '0;
      bus1.zero    = 1'b0;
      checkCount   = 0;
      passCount    = 0;
      failCount    = 0;
      modelInstret = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      pushStb("reset", FETCH, 9'h000);
      checkOutput(1, 0);
      reset = 1'b0;

      runAlu("addu", 32'h00221821, 3'd0, 1'b0, 2'd0, 5'b11000, 2'd1);
      runAlu("subu", 32'h00221823, 3'd1, 1'b0, 2'd0, 5'b11000, 2'd1);
      runAlu("ori",  32'h34220005, 3'd2, 1'b1, 2'd0, 5'b11100, 2'd0);
      runAlu("lui",  32'h3C011234, 3'd3, 1'b1, 2'd2, 5'b11100, 2'd0);

      applyStimulus(0, 32'h8C220004, 1'b0);
      pushStb("lw.fetch", FETCH, S_IR);
      pushStb("lw.dcd", DCD, 9'h000);
      pushExp("lw.exe", EXE, 9'h000, 5'b11100, 3'd0, 1'b1, 2'd1, 2'd0, 2'd0);
      pushStb("lw.ma", MA, 9'h000);
      pushExp("lw.wb", WB, S_PC | S_REG, 5'b00111, 3'd0, 1'b0, 2'd1, 2'd0, 2'd1);
      checkOutput(5, 0);

      applyStimulus(0, 32'hAC220004, 1'b0);
      pushStb("sw.fetch", FETCH, S_IR);
      pushStb("sw.dcd", DCD, 9'h000);
      pushExp("sw.exe", EXE, 9'h000, 5'b11100, 3'd0, 1'b1, 2'd1, 2'd0, 2'd0);
      pushStb("sw.ma", MA, S_PC | S_MEM);
      checkOutput(4, 0);

      applyStimulus(0, 32'h10220003, 1'b1);
      pushStb("beq1.fetch", FETCH, S_IR);
      pushStb("beq1.dcd", DCD, 9'h000);
      pushExp("beq1.br", BR, S_PC | S_NPC, 5'b10000, 3'd1, 1'b0, 2'd0, 2'd0, 2'd0);
      checkOutput(3, 0);

      applyStimulus(0, 32'h10220003, 1'b0);
      pushStb("beq0.fetch", FETCH, S_IR);
      pushStb("beq0.dcd", DCD, 9'h000);
      pushExp("beq0.br", BR, S_PC | S_NPC, 5'b10000, 3'd1, 1'b0, 2'd0, 2'd0, 2'd0);
      checkOutput(3, 0);

      applyStimulus(0, 32'h08000C00, 1'b0);
      pushStb("j.fetch", FETCH, S_IR);
      pushStb("j.dcd", DCD, 9'h000);
      pushStb("j.jmp", JMP, S_PC | S_J);
      checkOutput(3, 0);

      applyStimulus(0, 32'h0C000C00, 1'b0);
      pushStb("jal.fetch", FETCH, S_IR);
      pushStb("jal.dcd", DCD, 9'h000);
      pushExp("jal.jmp", JMP, S_PC | S_JAL | S_REG, 5'b00011, 3'd0, 1'b0, 2'd0, 2'd2, 2'd2);
      checkOutput(3, 0);

      applyStimulus(0, 32'h03E00008, 1'b0);
      pushStb("jr.fetch", FETCH, S_IR);
      pushStb("jr.dcd", DCD, 9'h000);
      pushStb("jr.jmp", JMP, S_PC | S_JR);
      checkOutput(3, 0);

      applyStimulus(0, 32'hFC000000, 1'b0);
      pushStb("ill.fetch", FETCH, S_IR);
      pushStb("ill.dcd", DCD, S_PC | S_ILL);
      checkOutput(2, 0);

      applyStimulus(0, 32'h00000000, 1'b0);
      pushStb("illfn.fetch", FETCH, S_IR);
      pushStb("illfn.dcd", DCD, S_PC | S_ILL);
      checkOutput(2, 0);

      runAlu("addu2", 32'h00221821, 3'd0, 1'b0, 2'd0, 5'b11000, 2'd1);

      // Reset lands during the memory-access cycle of a store
      applyStimulus(0, 32'hAC220004, 1'b0);
      pushStb("swrst.fetch", FETCH, S_IR);
      pushStb("swrst.dcd", DCD, 9'h000);
      pushStb("swrst.exe", EXE, 9'h000);
      checkOutput(3, 0);
      reset = 1'b1;
      pushStb("swrst.ma", MA, 9'h000);
      modelInstret = 32'd0;
      pushStb("swrst.after", FETCH, 9'h000);
      checkOutput(2, 0);
      reset = 1'b0;

      runAlu("addu3", 32'h00221821, 3'd0, 1'b0, 2'd0, 5'b11000, 2'd1);
      pushStb("addu3.next", FETCH, S_IR);
      checkOutput(1, 0);

      // Halting instance: it has retired nothing, and reset exits HALT
      modelInstret = 32'd0;
      reset = 1'b1;
      pushStb("halt.pre", HALT, 9'h000);
      pushStb("halt.rst", FETCH, 9'h000);
      checkOutput(2, 1);
      reset = 1'b0;
      applyStimulus(1, 32'hFC000000, 1'b0);
      pushStb("halt.fetch", FETCH, S_IR);
      pushStb("halt.dcd", DCD, S_ILL);
      for (int k = 0; k < 10; k++) pushStb("halt.hold", HALT, 9'h000);
      checkOutput(12, 1);
      reset = 1'b1;
      pushStb("halt.rst2", HALT, 9'h000);
      pushStb("halt.rst3", FETCH, 9'h000);
      checkOutput(2, 1);
      reset = 1'b0;
      pushStb("halt.refetch", FETCH, S_IR);
      checkOutput(1, 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
